fetch: RTL
==========

# fetch

Instruction-fetch stage of the ucrv32 pipeline, directly upstream of decode. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. Responses are buffered in a small FIFO, and decode is handed a registered `instruction_o`/`pc_o` pair with a valid flag. Branch/jump redirects from execute flush all in-flight and buffered fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: response buffer entries; also the outstanding-request limit. Legal values are 2..8.
- `clk_i`  input  1  clock; all logic on rising edge. One clock domain.
- `rst_i`  input  1  reset, synchronous, active-high.
- `imem_req_o`  output  1  request valid.
- `imem_addr_o`  output  32  word address; bits [1:0] always 0.
- `imem_gnt_i`  input  1  request accepted this cycle (`imem_req_o && imem_gnt_i`).
- `imem_rvalid_i`  input  1  response valid; at least 1 cycle after grant, in grant order.
- `imem_rdata_i`  input  32  instruction word, valid with `imem_rvalid_i`.
- `redirect_i`  input  1  taken branch/jump from execute.
- `redirect_pc_i`  input  32  target; bits [1:0] ignored (forced 0).
- `stall_i`  input  1  decode cannot accept this cycle.
- `valid_o`  output  1  `instruction_o`/`pc_o` hold a real instruction.
- `instruction_o`  output  32  instruction to decode; 32'h0000_0013 (NOP) when `!valid_o`.
- `pc_o`  output  32  address of `instruction_o`.

## Operation
- State:
  - `pc_q`: next address to request.
  - `outstanding`: granted requests not yet answered, 0..FIFO_DEPTH.
  - `discard`: responses to drop, 0..FIFO_DEPTH.
  - FIFO of {pc, instr}, with count `fifo_cnt`.
  - Output register holding {valid, pc, instr}.
- Issue rule:
  - Assert `imem_req_o` when `outstanding + fifo_cnt + valid_o(held by stall) < FIFO_DEPTH + 1` and no flush is pending.
  - `imem_addr_o = pc_q`.
  - On grant: `pc_q <= pc_q + 4` (wraps mod 2^32), `outstanding++`.
- Handshake: once `imem_req_o` rises, it and `imem_addr_o` stay stable until granted. Redirect does not retract an ungranted request.
- Response handling:
  - If `discard > 0`: drop the response and decrement `discard`.
  - Otherwise: push {pc of that request, rdata}. The PC tag FIFO is written at grant.
  - `outstanding--` in both cases.
- Output advance: when `!valid_o || !stall_i`, load the output register from the FIFO head (pop) if non-empty; otherwise set `valid_o <= 0`.
- Redirect, registered in cycle N (takes priority over everything):
  - FIFO cleared; `valid_o <= 0`.
  - `discard <= outstanding` after this cycle's grant/response updates, plus 1 if a request is pending ungranted. That request's response is dropped once granted.
  - `pc_q <= {redirect_pc_i[31:2], 2'b00}`.
  - Redirect overrides `stall_i`.
- Grant, response, redirect and pop may all occur in one cycle. Counters use net increment/decrement.
- Overflow is impossible by the credit rule. A response arriving with `outstanding == 0` is a protocol error: ignore it (assertion in bench).

## Timing
- Reset values:
  - `imem_req_o = 0`, `imem_addr_o = RESET_PC`
  - `valid_o = 0`, `instruction_o = 32'h0000_0013`, `pc_o = 32'h0`
  - counters 0, FIFO empty.
- First `imem_req_o = 1` the cycle after `rst_i` deasserts.
- Reset asserted mid-operation: the next edge returns all state to reset values. Responses in flight are the memory's responsibility; memory is reset on the same `rst_i`.
- Latency with zero-wait memory (grant same cycle, rvalid next cycle):
  - request at N → FIFO write at N+1 → `valid_o` at N+2.
  - Sustained throughput is 1 instruction/cycle with `FIFO_DEPTH >= 2`.
- Redirect at cycle N with no ungranted request pending: target requested at N+1, `valid_o` for target earliest at N+3.
- `stall_i` holds the output register unchanged (valid, pc, instr). Requests continue until credits are exhausted.

## Test plan
- Reset release, zero-wait memory returning addr-as-data: `imem_addr_o` = 0x0, 0x4, 0x8… on consecutive cycles; `valid_o` first at cycle 2 with `pc_o=0`, then one instruction/cycle, with `pc_o` matching `instruction_o`.
- `stall_i` high for 5 cycles after 3 instructions delivered: outputs frozen at `pc_o=0x8`; `imem_req_o` drops after FIFO_DEPTH extra grants. On release, 0xC, 0x10… follow with no loss or duplication.
- Redirect to 0x0000_0103 while 2 requests are outstanding: both responses dropped, next request addr 0x100, first `valid_o` shows `pc_o=0x100`, no stale instruction reaches `valid_o`.
- Memory withholds grant 3 cycles, redirect arrives during the wait: `imem_addr_o` stays constant until grant, the response to it is discarded, and the target is fetched next.
- Redirect, rvalid and `stall_i` in the same cycle: FIFO empty and `valid_o=0` next cycle; the arriving data is dropped.
- PC wrap: `RESET_PC=32'hFFFF_FFF8` gives addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's instruction-memory bus, execute redirect and
// decode hand-off. The fetch stage sits on the master side.
interface fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, instruction_o, pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests,
// buffers responses and hands decode a registered {valid, pc, instruction}.
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic     clk_i,
    input logic     rst_i,
    fetch_if.master bus
);
    localparam int          PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int          SW  = CW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request side: addr_reg is what is on the bus, pc_reg the next address to issue.
    logic          req_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   pc_reg;
    logic [CW-1:0] out_cnt_reg;
    logic [CW-1:0] discard_reg;

    logic [31:0]   tag_mem [FIFO_DEPTH];
    logic [PW-1:0] tag_wr_ptr_reg;
    logic [PW-1:0] tag_rd_ptr_reg;

    logic [31:0]   fifo_pc_mem    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] fifo_cnt_reg;

    logic          valid_reg;
    logic [31:0]   out_pc_reg;
    logic [31:0]   out_instr_reg;

    logic          granted, resp, keep, advance, pop, bypass, push, slot_free, credit, valid_next;
    logic [31:0]   target, launch_pc, tag_head;
    logic [CW-1:0] out_next, fifo_next, discard_next;
    logic [SW-1:0] credit_sum;

    assign granted   = req_reg & bus.imem_gnt_i;
    assign slot_free = ~req_reg | bus.imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp      = bus.imem_rvalid_i & (out_cnt_reg != '0);
    assign keep      = resp & (discard_reg == '0) & ~bus.redirect_i;
    assign advance   = ~valid_reg | ~bus.stall_i;
    assign pop       = ~bus.redirect_i & advance & (fifo_cnt_reg != '0);
    assign bypass    = ~bus.redirect_i & advance & (fifo_cnt_reg == '0) & keep;
    assign push      = keep & ~bypass;
    assign target    = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign launch_pc = bus.redirect_i ? target : pc_reg;
    assign tag_head  = tag_mem[tag_rd_ptr_reg];

    assign out_next     = out_cnt_reg + CW'(granted) - CW'(resp);
    assign fifo_next    = bus.redirect_i ? '0 : fifo_cnt_reg + CW'(push) - CW'(pop);
    assign valid_next   = bus.redirect_i ? 1'b0 : (advance ? (pop | bypass) : valid_reg);
    // An ungranted request pending at redirect is discarded too, once granted.
    assign discard_next = bus.redirect_i ? out_next + CW'(req_reg & ~bus.imem_gnt_i)
                                         : discard_reg - CW'(resp & (discard_reg != '0));

    // Every request issued must find room in the FIFO or the output register.
    assign credit_sum = SW'(out_next) + SW'(fifo_next) + SW'(valid_next);
    assign credit     = (credit_sum < SW'(FIFO_DEPTH + 1)) && (out_next < CW'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_reg        <= 1'b0;
            addr_reg       <= RESET_PC;
            pc_reg         <= RESET_PC;
            out_cnt_reg    <= '0;
            discard_reg    <= '0;
            tag_wr_ptr_reg <= '0;
            tag_rd_ptr_reg <= '0;
        end else begin
            if (slot_free) begin
                req_reg  <= credit;
                addr_reg <= launch_pc;
                pc_reg   <= credit ? launch_pc + 32'd4 : launch_pc;
            end else if (bus.redirect_i) begin
                pc_reg <= target;
            end
            out_cnt_reg <= out_next;
            discard_reg <= discard_next;
            if (granted) tag_wr_ptr_reg <= ptr_inc(tag_wr_ptr_reg);
            if (resp)    tag_rd_ptr_reg <= ptr_inc(tag_rd_ptr_reg);
        end
    end

    always_ff @(posedge clk_i) begin
        if (granted) tag_mem[tag_wr_ptr_reg] <= addr_reg;
        if (push) begin
            fifo_pc_mem[wr_ptr_reg]    <= tag_head;
            fifo_instr_mem[wr_ptr_reg] <= bus.imem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.redirect_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            fifo_cnt_reg <= fifo_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg     <= 1'b0;
            out_pc_reg    <= 32'h0;
            out_instr_reg <= NOP;
        end else if (bus.redirect_i) begin
            valid_reg     <= 1'b0;
            out_instr_reg <= NOP;
        end else if (advance) begin
            if (pop) begin
                valid_reg     <= 1'b1;
                out_pc_reg    <= fifo_pc_mem[rd_ptr_reg];
                out_instr_reg <= fifo_instr_mem[rd_ptr_reg];
            end else if (bypass) begin
                // Empty FIFO: a fresh response goes straight to decode.
                valid_reg     <= 1'b1;
                out_pc_reg    <= tag_head;
                out_instr_reg <= bus.imem_rdata_i;
            end else begin
                valid_reg     <= 1'b0;
                out_instr_reg <= NOP;
            end
        end
    end

    assign bus.imem_req_o    = req_reg;
    assign bus.imem_addr_o   = addr_reg;
    assign bus.valid_o       = valid_reg;
    assign bus.pc_o          = out_pc_reg;
    assign bus.instruction_o = out_instr_reg;
endmodule
